// File: rtl/sram_controller.sv
// Bridges 32-bit MEM-stage word loads/stores onto a 16-bit asynchronous SRAM as two halfword phases,
// holding ready low while the access is in flight.
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_we_n
);

    // state | meaning
    // IDLE  | waiting for a request; latches op, index and data when one arrives
    // LOW   | halfword {index,0} access, WAIT_CYCLES+1 cycles
    // HIGH  | halfword {index,1} access, WAIT_CYCLES+1 cycles
    // DONE  | one-cycle completion, ready high, read_data holds the full word
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t            state;
    state_t            state_next;
    logic              op_wr;
    logic [ADDR_W-2:0] idx;
    logic [15:0]       wdata_hi;
    logic [CNT_W-1:0]  cnt;
    logic              req;
    logic              phase_end;
    logic [ADDR_W-2:0] idx_in;

    assign req       = wr_en | rd_en;
    assign phase_end = (cnt == '0);
    assign idx_in    = (ADDR_W-1)'((address - 32'(BASE_ADDR)) >> 2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        case (state)
            IDLE: begin
                ready = !req;
                if (req) state_next = LOW;
            end
            LOW: begin
                sram_we_n  = !op_wr;
                sram_dq_oe = op_wr;
                if (phase_end) state_next = HIGH;
            end
            HIGH: begin
                sram_we_n  = !op_wr;
                sram_dq_oe = op_wr;
                if (phase_end) state_next = DONE;
            end
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address and write data are registered one phase ahead so they are stable for the whole strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_wr       <= 1'b0;
            idx         <= '0;
            wdata_hi    <= '0;
            cnt         <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op_wr       <= wr_en;
                        idx         <= idx_in;
                        wdata_hi    <= write_data[31:16];
                        cnt         <= CNT_LOAD;
                        sram_addr   <= {idx_in, 1'b0};
                        sram_dq_out <= write_data[15:0];
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        if (!op_wr) read_data[15:0] <= sram_dq_in;
                        cnt         <= CNT_LOAD;
                        sram_addr   <= {idx, 1'b1};
                        sram_dq_out <= wdata_hi;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        if (!op_wr) read_data[31:16] <= sram_dq_in;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
